// File: rtl/bridge_tx_arbiter.sv
// rtl/bridge_tx_arbiter.sv - round-robin arbiter sharing one bridge_tx response channel (option: BRIDGE_TX_ARB_PRIO_EN)
module bridge_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       res_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        busy,
  output logic [15:0]                 tx_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
`ifdef BRIDGE_TX_ARB_PRIO_EN
  // Size of the round-robin ring formed by requesters 1..N_REQ-1.
  localparam int NR1 = (N_REQ > 1) ? N_REQ - 1 : 1;
`endif

  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic                  r_valid;
  logic [15:0]           r_tx_count;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [N_REQ-1:0]      w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_hs;
  int                    idx;

  // Pick the winner by scanning forward from the slot after the last grant.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
`ifdef BRIDGE_TX_ARB_PRIO_EN
    if (req_valid[0]) begin
      w_found = 1'b1;
    end else if (N_REQ > 1) begin
      for (int k = 1; k <= NR1; k++) begin
        idx = ((int'(r_rr_ptr) + NR1 - 1 + k) % NR1) + 1;
        if (!w_found && req_valid[idx]) begin
          w_found  = 1'b1;
          w_winner = ID_WIDTH'(idx);
        end
      end
    end
`else
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'(idx);
      end
    end
`endif
  end

  // One-hot ready for the winner and the matching data slice.
  always_comb begin
    w_ready = '0;
    w_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_found && w_winner == ID_WIDTH'(i)) begin
        w_ready[i] = 1'b1;
        w_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = (rst_n && r_state == IDLE) ? w_ready : '0;
  assign w_hs      = |(req_valid & req_ready);

  // Holding register, grant tracking and delivered-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_grant    <= '0;
      r_rr_ptr   <= ID_WIDTH'(N_REQ - 1);
      r_valid    <= 1'b0;
      r_tx_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_buf   <= w_data;
            r_grant <= w_winner;
`ifdef BRIDGE_TX_ARB_PRIO_EN
            if (w_winner != '0) r_rr_ptr <= w_winner;
`else
            r_rr_ptr <= w_winner;
`endif
            r_valid <= 1'b1;
            r_state <= ISSUE;
          end
        end
        default: begin
          if (r_valid && res_ready) begin
            r_valid    <= 1'b0;
            r_tx_count <= r_tx_count + 16'd1;
            r_state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign res_data  = r_buf;
  assign res_valid = r_valid;
  assign grant_id  = r_grant;
  assign busy      = (r_state == ISSUE);
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_bridge_tx_arbiter.sv
// tb/tb_bridge_tx_arbiter.sv - scoreboard bench for bridge_tx_arbiter
module tb_bridge_tx_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0][15:0]  rd;
  logic [63:0]       req_data;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [15:0]       res_data;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       tx_count;

  int errors = 0;
  int checks = 0;
  logic [17:0] q[$];

  assign req_data = rd;

  bridge_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(16), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .grant_id(grant_id), .busy(busy), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [15:0] d);
    q.push_back({id, d});
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drain_left"}, q.size(), 0);
    q.delete();
  endtask

  // Monitor: every accepted word is checked against the scoreboard head.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_accept", {14'd0, grant_id, res_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("accept_word", {14'd0, grant_id, res_data}, {14'd0, e});
        end
      end
    end
  end

  initial begin
    rd[0] = 16'h1234; rd[1] = 16'h1111; rd[2] = 16'hA5A5; rd[3] = 16'h3333;
    rst_n = 1'b0; req_valid = 4'b0001; res_ready = 1'b1;
    #12;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_res_data", res_data, 0);
    req_valid = 4'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: single word, first-transaction latency
    req_valid = 4'b0001; res_ready = 1'b1;
    push(2'd0, 16'h1234);
    @(negedge clk);
    chk("t1_req_ready_c0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = 4'b0;
    @(negedge clk);
    chk("t1_res_valid_c1", res_valid, 1);
    chk("t1_busy_c1", busy, 1);
    @(negedge clk);
    chk("t1_tx_count_c2", tx_count, 1);
    chk("t1_busy_c2", busy, 0);
    wait_drain("t1");

    // 2: all valid, rotation 0,1,2,3,0 from reset
    do_reset();
    res_ready = 1'b1; req_valid = 4'b1111;
    push(0, rd[0]); push(1, rd[1]); push(2, rd[2]); push(3, rd[3]); push(0, rd[0]);
    wait_drain("t2");
    @(posedge clk); #1 req_valid = 4'b0;
    @(negedge clk);
    chk("t2_tx_count", tx_count, 5);

    // 3: backpressure for 20 cycles, rr_ptr=0 so requester 2 wins
    res_ready = 1'b0;
    @(posedge clk); #1 req_valid = 4'b0100;
    push(2, 16'hA5A5);
    @(posedge clk); #1 req_valid = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t3_hold", {res_valid, busy, grant_id, req_ready, res_data},
          {1'b1, 1'b1, 2'd2, 4'b0000, 16'hA5A5});
      @(posedge clk); #1;
    end
    req_valid = 4'b0; res_ready = 1'b1;
    wait_drain("t3");
    @(negedge clk);
    chk("t3_tx_count", tx_count, 6);

    // 6: requester 3 drops before winning while requester 1 holds the grant
    res_ready = 1'b0;
    @(posedge clk); #1 req_valid = 4'b0010;
    push(1, rd[1]); push(0, rd[0]);
    @(posedge clk); #1 req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_ready3", req_ready, 4'b0000);
      @(posedge clk); #1;
    end
    req_valid = 4'b0001; res_ready = 1'b1;
    @(negedge clk);
    chk("t6_ready3_low", req_ready[3], 0);
    wait_drain("t6");
    @(posedge clk); #1 req_valid = 4'b0;

    // 4: asynchronous reset while holding 16'hBEEF
    rd[2] = 16'hBEEF; res_ready = 1'b0;
    @(posedge clk); #1 req_valid = 4'b0100;
    @(posedge clk); #1 req_valid = 4'b0;
    @(negedge clk);
    chk("t4_holding", {res_valid, res_data}, {1'b1, 16'hBEEF});
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_valid", res_valid, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_count", tx_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = 4'b1010; res_ready = 1'b1;
    push(1, rd[1]);
    @(posedge clk); #1 req_valid = 4'b0;
    wait_drain("t4");
    @(negedge clk);
    chk("t4_tx_count", tx_count, 1);

    // 5: requesters 0 and 2 constantly valid
    do_reset();
    res_ready = 1'b1; req_valid = 4'b0101;
`ifdef BRIDGE_TX_ARB_PRIO_EN
    push(0, rd[0]); push(0, rd[0]); push(0, rd[0]); push(0, rd[0]);
`else
    push(0, rd[0]); push(2, rd[2]); push(0, rd[0]); push(2, rd[2]);
`endif
    wait_drain("t5");
    @(posedge clk); #1 req_valid = 4'b0;
    repeat (3) @(negedge clk);
    chk("t5_tx_count", tx_count, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
